// File: rtl/mips_ld_pkg.sv
// mips_ld_pkg: shared definitions for the load extension controller.
//   - ld_op encodings (MIPS opcode[2:0] of the load instructions)
//   - FSM state type for load_ext_ctrl
//   - ld_misaligned(): alignment rule for a given op and byte offset
package mips_ld_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StErr
  } ld_state_e;

  // Unknown op codes behave as LW, so they need word alignment too.
  function automatic logic ld_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      LD_LB, LD_LBU: mis = 1'b0;
      LD_LH, LD_LHU: mis = off[0];
      default:       mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ld_extend.sv
// ld_extend: combinational lane select and sign/zero extension of a loaded word.
// Ports:
//   word_i     32-bit word returned by data memory
//   addr_lo_i  byte offset addr[1:0] of the load
//   op_i       load type (mips_ld_pkg encodings; unknown codes pass the word)
//   data_o     lane-selected, extended 32-bit result
module ld_extend
  import mips_ld_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lanes; halfwords use addr[1] only so addr[0] is ignored.
  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (op_i)
      LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {24'h0, byte_sel};
      LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_ext_ctrl.sv
// load_ext_ctrl: multi-cycle load controller between the MEM stage and a
// handshaked data memory. Accepts one load, issues a word-aligned read,
// waits for data, extends the addressed lane and returns it registered
// with a one-cycle done pulse. ld_ready low stalls the pipeline.
// Build option: LOAD_ALIGN_CHECK_EN - when defined, misaligned loads pulse
// ld_exc for one cycle and issue no memory access; otherwise ld_exc is 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_valid/ld_op/ld_addr   load request from MEM stage
//   ld_ready                 idle, able to accept (from state only)
//   ld_done/ld_rdata         done pulse and registered result
//   ld_exc                   misalignment pulse
//   dmem_req/dmem_addr       memory read request, word address
//   dmem_gnt                 memory accepted request
//   dmem_rvalid/dmem_rdata   read data return
module load_ext_ctrl
  import mips_ld_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [2:0]        ld_op,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_exc,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata
);

  ld_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]       ext_data;

  ld_extend u_ld_extend (
    .word_i    (dmem_rdata),
    .addr_lo_i (off_q),
    .op_i      (op_q),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (ld_valid) begin
          op_d    = ld_op;
          off_d   = ld_addr[1:0];
          waddr_d = {ld_addr[ADDR_W-1:2], 2'b00};
          state_d = StReq;
`ifdef LOAD_ALIGN_CHECK_EN
          if (ld_misaligned(ld_op, ld_addr[1:0])) begin
            state_d = StErr;
          end
`endif
        end
      end
      // rvalid is deliberately ignored until the request has been granted.
      StReq: begin
        if (dmem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (dmem_rvalid) begin
          rdata_d = ext_data;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
`ifdef LOAD_ALIGN_CHECK_EN
      StErr:  state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= LD_LW;
      off_q   <= 2'b00;
      waddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      rdata_q <= rdata_d;
    end
  end

  assign ld_ready  = (state_q == StIdle);
  assign ld_done   = (state_q == StDone);
  assign dmem_req  = (state_q == StReq);
  assign dmem_addr = waddr_q;
  assign ld_rdata  = rdata_q;
`ifdef LOAD_ALIGN_CHECK_EN
  assign ld_exc    = (state_q == StErr);
`else
  assign ld_exc    = 1'b0;
`endif

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Self-checking bench for load_ext_ctrl: scenario tasks push expected load
// results into a queue and pop them when the DUT signals done.
module tb_load_ext_ctrl;
  import mips_ld_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic        ld_ready;
  logic        ld_done;
  logic [31:0] ld_rdata;
  logic        ld_exc;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  load_ext_ctrl #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_op       (ld_op),
    .ld_addr     (ld_addr),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .ld_rdata    (ld_rdata),
    .ld_exc      (ld_exc),
    .dmem_req    (dmem_req),
    .dmem_addr   (dmem_addr),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  // Observations filled in by run_load.
  int          obs_lat;
  int          obs_req_cycles;
  logic        obs_addr_stable;
  logic        obs_ready_low;
  logic        obs_done;
  logic [31:0] obs_addr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one load with the given grant/rvalid delays. rv_early pulses a
  // bogus rvalid in the first REQ cycle. Returns in the DONE cycle.
  task automatic run_load(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] word, input int gnt_dly,
                          input int rv_dly, input logic rv_early);
    int cyc;
    obs_req_cycles  = 0;
    obs_addr_stable = 1'b1;
    obs_ready_low   = 1'b1;
    obs_done        = 1'b0;
    obs_lat         = 0;
    ld_valid = 1'b1;
    ld_op    = op;
    ld_addr  = addr;
    step();
    cyc      = 1;
    ld_valid = 1'b0;
    obs_addr = dmem_addr;
    for (int i = 0; i <= gnt_dly; i++) begin
      if (dmem_req === 1'b1) obs_req_cycles++;
      if (dmem_addr !== obs_addr) obs_addr_stable = 1'b0;
      if (ld_ready !== 1'b0) obs_ready_low = 1'b0;
      dmem_gnt    = (i == gnt_dly);
      dmem_rvalid = rv_early && (i == 0);
      dmem_rdata  = (rv_early && (i == 0)) ? 32'hDEAD_BEEF : 32'h0;
      step();
      cyc++;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    for (int i = 0; i <= rv_dly; i++) begin
      if (ld_ready !== 1'b0) obs_ready_low = 1'b0;
      if (dmem_req === 1'b1) obs_req_cycles++;
      dmem_rvalid = (i == rv_dly);
      dmem_rdata  = (i == rv_dly) ? word : 32'h5A5A_5A5A;
      step();
      cyc++;
    end
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    for (int i = 0; i < 8 && !obs_done; i++) begin
      if (ld_done === 1'b1) begin
        obs_done = 1'b1;
        obs_lat  = cyc;
      end else begin
        if (ld_ready !== 1'b0) obs_ready_low = 1'b0;
        step();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({ld_ready, ld_done, ld_exc, dmem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/done/exc/req=%b want 1000",
               {ld_ready, ld_done, ld_exc, dmem_req});
    end
    checks++;
    if (dmem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 00000000", dmem_addr);
    end
    checks++;
    if (ld_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 00000000", ld_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lb_min_latency();
    logic [31:0] exp;
    exp_q.push_back(32'hFFFF_FF80);
    run_load(LD_LB, 32'h0000_1003, 32'h80FF_0000, 0, 0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (ld_rdata !== exp) begin
      errors++;
      $display("FAIL lb_rdata: got %h want %h", ld_rdata, exp);
    end
    checks++;
    if (!obs_done || obs_lat != 3) begin
      errors++;
      $display("FAIL lb_latency: got done=%0b lat=%0d want done=1 lat=3", obs_done, obs_lat);
    end
    checks++;
    if (obs_req_cycles != 1 || obs_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL lb_request: got req_cycles=%0d addr=%h want 1 00001000",
               obs_req_cycles, obs_addr);
    end
    step();
    checks++;
    if ({ld_ready, ld_done} !== 2'b10) begin
      errors++;
      $display("FAIL lb_done_pulse: got rdy/done=%b want 10", {ld_ready, ld_done});
    end
  endtask

  task automatic test_lane_extend();
    logic [2:0]  ops[6]   = '{LD_LBU, LD_LHU, LD_LB, LD_LH, LD_LW, 3'b111};
    logic [31:0] addrs[6] = '{32'h1003, 32'h1002, 32'h1001, 32'h1002, 32'h2000, 32'h1000};
    logic [31:0] words[6] = '{32'h80FF_0000, 32'h8001_1234, 32'h0000_7F00,
                              32'h7FFF_0000, 32'h1234_5678, 32'h8765_4321};
    logic [31:0] exps[6]  = '{32'h0000_0080, 32'h0000_8001, 32'h0000_007F,
                              32'h0000_7FFF, 32'h1234_5678, 32'h8765_4321};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      run_load(ops[i], addrs[i], words[i], 0, 0, 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (!obs_done || ld_rdata !== exp) begin
        errors++;
        $display("FAIL lane_extend[%0d]: got done=%0b rdata=%h want done=1 rdata=%h",
                 i, obs_done, ld_rdata, exp);
      end
      step();
    end
  endtask

  task automatic test_lh_delayed();
    logic [31:0] exp;
    exp_q.push_back(32'hFFFF_F00D);
    run_load(LD_LH, 32'h0000_1000, 32'h0000_F00D, 2, 3, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (ld_rdata !== exp) begin
      errors++;
      $display("FAIL lh_delay_rdata: got %h want %h", ld_rdata, exp);
    end
    checks++;
    if (obs_req_cycles != 3 || !obs_addr_stable || obs_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL lh_delay_req: got cycles=%0d stable=%0b addr=%h want 3 1 00001000",
               obs_req_cycles, obs_addr_stable, obs_addr);
    end
    checks++;
    if (!obs_ready_low || !obs_done || obs_lat != 8) begin
      errors++;
      $display("FAIL lh_delay_timing: got ready_low=%0b done=%0b lat=%0d want 1 1 8",
               obs_ready_low, obs_done, obs_lat);
    end
    step();
  endtask

  task automatic test_lw_misaligned();
`ifdef LOAD_ALIGN_CHECK_EN
    logic [31:0] prev;
    prev     = ld_rdata;
    ld_valid = 1'b1;
    ld_op    = LD_LW;
    ld_addr  = 32'h0000_1002;
    step();
    ld_valid = 1'b0;
    checks++;
    if ({ld_exc, dmem_req, ld_ready} !== 3'b100 || ld_rdata !== prev) begin
      errors++;
      $display("FAIL lw_mis_exc: got exc/req/rdy=%b rdata=%h want 100 rdata=%h",
               {ld_exc, dmem_req, ld_ready}, ld_rdata, prev);
    end
    step();
    checks++;
    if ({ld_exc, dmem_req, ld_ready} !== 3'b001) begin
      errors++;
      $display("FAIL lw_mis_idle: got exc/req/rdy=%b want 001", {ld_exc, dmem_req, ld_ready});
    end
`else
    logic [31:0] exp;
    exp_q.push_back(32'hCAFE_F00D);
    run_load(LD_LW, 32'h0000_1002, 32'hCAFE_F00D, 0, 0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (ld_rdata !== exp || obs_addr !== 32'h0000_1000 || ld_exc !== 1'b0) begin
      errors++;
      $display("FAIL lw_unaligned: got rdata=%h addr=%h exc=%b want %h 00001000 0",
               ld_rdata, obs_addr, ld_exc, exp);
    end
    step();
`endif
  endtask

  task automatic test_reset_mid();
    ld_valid = 1'b1;
    ld_op    = LD_LB;
    ld_addr  = 32'h0000_1000;
    step();
    ld_valid = 1'b0;
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({ld_ready, ld_done, dmem_req} !== 3'b100 || ld_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got rdy/done/req=%b rdata=%h want 100 00000000",
               {ld_ready, ld_done, dmem_req}, ld_rdata);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    checks++;
    if ({ld_ready, ld_done, dmem_req} !== 3'b100 || ld_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_late_rvalid: got rdy/done/req=%b rdata=%h want 100 00000000",
               {ld_ready, ld_done, dmem_req}, ld_rdata);
    end
  endtask

  task automatic test_rvalid_in_req();
    logic [31:0] exp;
    exp_q.push_back(32'h0000_0055);
    run_load(LD_LBU, 32'h0000_2000, 32'h1234_5655, 1, 0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (ld_rdata !== exp || !obs_done || obs_lat != 4) begin
      errors++;
      $display("FAIL early_rvalid: got rdata=%h done=%0b lat=%0d want %h 1 4",
               ld_rdata, obs_done, obs_lat, exp);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    exp_q.push_back(32'hFFFF_8001);
    run_load(LD_LH, 32'h0000_3002, 32'h8001_0000, 0, 0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (ld_rdata !== exp) begin
      errors++;
      $display("FAIL b2b_first: got %h want %h", ld_rdata, exp);
    end
    // Request offered during DONE must not be taken.
    ld_valid = 1'b1;
    ld_op    = LD_LW;
    ld_addr  = 32'h0000_3000;
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_in_done: got %b want 0", ld_ready);
    end
    step();
    checks++;
    if ({ld_ready, dmem_req} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_gap: got rdy/req=%b want 10", {ld_ready, dmem_req});
    end
    exp_q.push_back(32'hA5A5_0F0F);
    run_load(LD_LW, 32'h0000_3000, 32'hA5A5_0F0F, 0, 0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (ld_rdata !== exp || obs_addr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL b2b_second: got rdata=%h addr=%h want %h 00003000",
               ld_rdata, obs_addr, exp);
    end
    step();
  endtask

  initial begin
    rst         = 1'b1;
    ld_valid    = 1'b0;
    ld_op       = LD_LW;
    ld_addr     = 32'h0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    test_reset();
    test_lb_min_latency();
    test_lane_extend();
    test_lh_delayed();
    test_lw_misaligned();
    test_rvalid_in_req();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
